dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Parametrised byte-addressable data memory with an integrated load/store formatter. It replaces the flat word memory and its combinational extend logic in the MEM stage. The block adds:
- true byte-lane stores placed by address offset
- a registered read with a valid handshake
- detection of misaligned and illegal accesses
- optional two-cycle splitting of accesses that cross a word boundary

## Interface
Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, ≥ 4
- ADDR_W, 32, byte-address width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present this cycle
- req_we  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are load-only)
- addr  in  ADDR_W  byte address
- wdata  in  32  store data, right-aligned
- req_ready  out  1  request accepted when req_valid && req_ready
- rsp_valid  out  1  one-cycle pulse per completed request
- rsp_rdata  out  32  formatted load data; 0 for stores and for errored loads
- misalign  out  1  qualifies rsp_valid; access was misaligned and suppressed
- illegal  out  1  qualifies rsp_valid; funct3 invalid for the operation

## Operation
- **Word index:** addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS. Byte order is little-endian.
- **Stores:**
  - Byte-lane mask: B → lane addr[1:0]; H → lanes addr[1:0], addr[1:0]+1; W → all four.
  - wdata is shifted left by 8*addr[1:0].
  - Unmasked lanes are untouched.
- **Loads:**
  - The selected bytes are shifted down.
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- **Illegal cases:** funct3 ∈ {011, 110, 111}, or a store with 100/101. Result: no write, rsp_rdata = 0, illegal = 1.
- **Boundary-crossing access:** H at offset 3, or W at offset 1–3. Handling depends on DMEM_SPLIT_EN (see Configuration).
- **State machine:**
  - States: IDLE, SECOND.
  - IDLE → SECOND when an accepted access crosses a word boundary and the macro is defined.
  - SECOND → IDLE unconditionally after one cycle.
  - req_ready = (state == IDLE).
- **Split access:**
  - First cycle accesses word k with the low-order bytes.
  - SECOND accesses word (k+1) mod DEPTH_WORDS with the remaining bytes.
  - For a load, the bytes are merged, then extended.
- **Errors:** misalign and illegal are never both 1. Illegal takes priority.

## Timing
- **Reset values:** state IDLE, rsp_valid 0, rsp_rdata 0, misalign 0, illegal 0. Memory contents are not reset.
- **Single-cycle access:** accepted at edge t, array written or read at t. rsp_valid, rsp_rdata and flags are registered and valid in cycle t+1.
- **Split access:**
  - Accepted at t; req_ready = 0 during cycle t+1; second word accessed at t+1.
  - rsp_valid in cycle t+2; req_ready = 1 again in cycle t+2.
- **Throughput:** back-to-back aligned requests give one response per cycle.
- **Ordering:** a store at t followed by a load of the same word at t+1 returns the new data. There is one port, so no write/read collision exists.
- **Reset mid-split:** aborts the access and no response is produced. The first-half bytes of a store remain written; the second half is not written.

## Configuration
- Macro: **DMEM_SPLIT_EN**.
- **Defined:**
  - In-word misaligned accesses (H at offset 1) complete in one cycle.
  - Boundary-crossing accesses use the IDLE/SECOND split.
  - misalign is never asserted.
- **Undefined:**
  - SECOND state is absent; req_ready is tied to 1.
  - Any access not naturally aligned (H with addr[0]=1, W with addr[1:0]≠0) sets misalign = 1.
  - Such an access writes nothing and returns rsp_rdata = 0, one cycle after acceptance.

## Structure
- **dmem_pkg** holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU
  - lsu_state_t enum {IDLE, SECOND}
  - function byte_mask(funct3, offset)
- **dmem_lane_ram** sub-module:
  - DEPTH_WORDS × 4 byte-lane array
  - single port: 4-bit byte enable, registered 32-bit read
- The top level holds the FSM, shift/merge/extend logic and the flag registers.

## Test plan
- SW 0x800000FF @0x10; then LB @0x10 → 0xFFFFFFFF; LBU @0x13 → 0x00000080; LH @0x12 → 0xFFFF8000; each rsp_valid one cycle after acceptance.
- SW 0xAABBCCDD @0x20; SB 0x11 @0x21; LW @0x20 → 0xAABB11DD (only lane 1 changed).
- DMEM_SPLIT_EN defined: SW 0x11223344 @0x0E → word 0x0C lanes 2/3 = 44/33, word 0x10 lanes 0/1 = 22/11; LW @0x0E → 0x11223344, req_ready low in cycle t+1, rsp_valid in t+2.
- DMEM_SPLIT_EN defined, DEPTH_WORDS = 16: LHU @0x3F → byte 0x3F low, byte 0x00 high (wrap).
- DMEM_SPLIT_EN undefined: SW @0x0E → misalign = 1, memory unchanged; LW @0x0E → rsp_rdata 0, misalign = 1.
- Store with funct3 = 100 → illegal = 1, no write; assert rst_n low during SECOND of a split SW → state IDLE, no rsp_valid, only first-word lanes changed.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressable data memory and its load/store formatter.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } lsu_state_t;

  // Lanes touched across a pair of words: [3:0] is word k, [7:4] is word k+1.
  function automatic logic [7:0] byte_mask(input logic [2:0] f3, input logic [1:0] offset);
    logic [7:0] m;
    case (f3[1:0])
      2'b00:   m = 8'b0000_0001;
      2'b01:   m = 8'b0000_0011;
      default: m = 8'b0000_1111;
    endcase
    return m << offset;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [31:0] s);
    logic [31:0] r;
    case (f3)
      F3_B:    r = {{24{s[7]}}, s[7:0]};
      F3_H:    r = {{16{s[15]}}, s[15:0]};
      F3_W:    r = s;
      F3_BU:   r = {24'h0, s[7:0]};
      F3_HU:   r = {16'h0, s[15:0]};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_lane_ram.sv
// Single-port word array split into four independently writable byte lanes, registered read.
module dmem_lane_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [3:0][7:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][i] <= wdata[8*i +: 8];
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_lsu.sv
// Data memory with byte-lane stores, sign/zero-extending loads and access-error flags.
// Define DMEM_SPLIT_EN to complete word-crossing accesses in two cycles instead of flagging them.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              misalign,
  output logic              illegal,
  output logic              dbg_state
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // rsp_valid pulses for exactly one cycle per transferred request, in order.

  lsu_state_t state_q, state_d;

  logic [1:0]    off;
  logic [AW-1:0] idx;
  logic          accept, is_illegal, crosses, unaligned, is_mis, split_go, ok;
  logic [7:0]    mask8;
  logic [63:0]   wd64;

  logic          ram_en;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_wdata, ram_rdata;

  logic          rsp_valid_q, mis_q, ill_q, load_q, split_q;
  logic [1:0]    off_q;
  logic [2:0]    f3_q;
  logic [AW-1:0] hi_idx_q;
  logic [3:0]    hi_be_q;
  logic [31:0]   hi_wdata_q, lo_q;
  logic [63:0]   merged;
  logic [31:0]   aligned;
  logic          unused_ok;

  assign off       = addr[1:0];
  assign idx       = addr[AW+1:2];
  assign accept    = req_valid && req_ready;
  assign crosses   = (funct3[1:0] == 2'b01 && off == 2'd3) || (funct3[1:0] == 2'b10 && off != 2'd0);
  assign unaligned = (funct3[1:0] == 2'b01 && off[0]) || (funct3[1:0] == 2'b10 && off != 2'd0);
  assign unused_ok = ^{addr[ADDR_W-1:AW+2], crosses, unaligned};

  always_comb begin
    is_illegal = 1'b0;
    case (funct3)
      3'b011, 3'b110, 3'b111: is_illegal = 1'b1;
      F3_BU, F3_HU:           is_illegal = req_we;
      default:                is_illegal = 1'b0;
    endcase
  end

`ifdef DMEM_SPLIT_EN
  assign is_mis    = 1'b0;
  assign split_go  = accept && !is_illegal && crosses;
  assign req_ready = (state_q == IDLE);
`else
  assign is_mis    = unaligned && !is_illegal;
  assign split_go  = 1'b0;
  assign req_ready = 1'b1;
`endif

  assign ok    = !is_illegal && !is_mis;
  assign mask8 = byte_mask(funct3, off);
  assign wd64  = {32'h0, wdata} << {off, 3'b000};

  always_comb begin
    state_d   = state_q;
    ram_en    = 1'b0;
    ram_be    = 4'b0000;
    ram_idx   = idx;
    ram_wdata = wd64[31:0];
    case (state_q)
      IDLE: begin
        ram_en = accept;
        ram_be = (accept && req_we && ok) ? mask8[3:0] : 4'b0000;
        if (split_go) state_d = SECOND;
      end
      SECOND: begin
        ram_en    = 1'b1;
        ram_idx   = hi_idx_q;
        ram_be    = hi_be_q;
        ram_wdata = hi_wdata_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  dmem_lane_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .be    (ram_be),
    .idx   (ram_idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      mis_q       <= 1'b0;
      ill_q       <= 1'b0;
      load_q      <= 1'b0;
      split_q     <= 1'b0;
      off_q       <= 2'd0;
      f3_q        <= 3'd0;
      hi_idx_q    <= '0;
      hi_be_q     <= 4'b0000;
      hi_wdata_q  <= 32'h0;
      lo_q        <= 32'h0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= 1'b0;
      if (accept) begin
        off_q       <= off;
        f3_q        <= funct3;
        load_q      <= !req_we && ok;
        mis_q       <= is_mis;
        ill_q       <= is_illegal;
        split_q     <= split_go;
        hi_idx_q    <= idx + AW'(1);
        hi_be_q     <= (req_we && ok) ? mask8[7:4] : 4'b0000;
        hi_wdata_q  <= wd64[63:32];
        rsp_valid_q <= !split_go;
      end
      // The first word's read data lands during SECOND; keep it for the merge.
      if (state_q == SECOND) begin
        lo_q        <= ram_rdata;
        rsp_valid_q <= 1'b1;
      end
    end
  end

  assign merged    = split_q ? {ram_rdata, lo_q} : {32'h0, ram_rdata};
  assign aligned   = 32'(merged >> {off_q, 3'b000});
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = (rsp_valid_q && load_q) ? load_extend(f3_q, aligned) : 32'h0;
  assign misalign  = rsp_valid_q && mis_q;
  assign illegal   = rsp_valid_q && ill_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: vector table with a response scoreboard plus a reset-abort sequence.
module tb_dmem_lsu;
  import dmem_pkg::*;

`ifdef DMEM_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mis;
    logic        ill;
    int          lat;
  } vec_t;

  logic        clk, rst_n, req_valid, req_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        req_ready, rsp_valid, misalign, illegal, dbg_state;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [49:0] exp_q[$];
  vec_t vecs[$];

  dmem_lsu #(.DEPTH_WORDS(16), .ADDR_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .misalign  (misalign),
    .illegal   (illegal),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input logic mis, input logic ill, input int lat);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.rdata = rd; v.mis = mis; v.ill = ill; v.lat = lat;
    vecs.push_back(v);
  endtask

  // driver: called at a negative edge, returns at the negative edge after acceptance
  task automatic do_req(input vec_t v);
    int waitc = 0;
    req_valid = 1'b1; req_we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
    while (!req_ready && waitc < 10) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 64'(req_ready), 64'(1));
      req_valid = 1'b0;
      return;
    end
    exp_q.push_back({16'(cyc + v.lat), v.mis, v.ill, v.rdata});
    @(negedge clk);
    chk($sformatf("ready_after_%h", v.addr), 64'(req_ready), 64'(v.lat == 1));
    req_valid = 1'b0;
  endtask

  // scoreboard
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 64'(rsp_valid), 64'(0));
      end else begin
        logic [49:0] e;
        e = exp_q.pop_front();
        chk("rsp_rdata", 64'(rsp_rdata), 64'(e[31:0]));
        chk("rsp_flags", 64'({misalign, illegal}), 64'(e[33:32]));
        chk("rsp_cycle", 64'(cyc[15:0]), 64'(e[49:34]));
      end
    end
  end

  initial begin
    vec_t v;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'd0; addr = 32'h0; wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_rsp_rdata", 64'(rsp_rdata), 64'(0));
    chk("reset_flags", 64'({misalign, illegal}), 64'(0));
    chk("reset_state", 64'(dbg_state), 64'(IDLE));
    chk("reset_ready", 64'(req_ready), 64'(1));
    rst_n = 1'b1;
    @(negedge clk);

    add(1, F3_W,  32'h10, 32'h800000FF, 32'h0, 0, 0, 1);
    add(0, F3_B,  32'h10, 32'h0, 32'hFFFFFFFF, 0, 0, 1);
    add(0, F3_BU, 32'h13, 32'h0, 32'h00000080, 0, 0, 1);
    add(0, F3_H,  32'h12, 32'h0, 32'hFFFF8000, 0, 0, 1);
    add(1, F3_W,  32'h20, 32'hAABBCCDD, 32'h0, 0, 0, 1);
    add(1, F3_B,  32'h21, 32'h12345611, 32'h0, 0, 0, 1);
    add(0, F3_W,  32'h20, 32'h0, 32'hAABB11DD, 0, 0, 1);
    add(0, F3_HU, 32'h22, 32'h0, 32'h0000AABB, 0, 0, 1);
    add(1, F3_W,  32'h24, 32'h01020304, 32'h0, 0, 0, 1);
    add(1, F3_H,  32'h26, 32'h5555BEEF, 32'h0, 0, 0, 1);
    add(0, F3_W,  32'h24, 32'h0, 32'hBEEF0304, 0, 0, 1);
    add(0, F3_H,  32'h26, 32'h0, 32'hFFFFBEEF, 0, 0, 1);
    add(0, F3_B,  32'h25, 32'h0, 32'h00000003, 0, 0, 1);
    add(0, F3_BU, 32'h27, 32'h0, 32'h000000BE, 0, 0, 1);
    add(1, 3'b100, 32'h20, 32'h77, 32'h0, 0, 1, 1);
    add(0, 3'b011, 32'h20, 32'h0, 32'h0, 0, 1, 1);
    add(1, 3'b110, 32'h20, 32'h66, 32'h0, 0, 1, 1);
    add(1, 3'b101, 32'h21, 32'h55, 32'h0, 0, 1, 1);
    add(0, F3_W,  32'h20, 32'h0, 32'hAABB11DD, 0, 0, 1);
    add(1, F3_W,  32'h0C, 32'hCAFEBABE, 32'h0, 0, 0, 1);
    add(1, F3_W,  32'h0E, 32'h11223344, 32'h0, !SPLIT, 0, SPLIT ? 2 : 1);
    add(0, F3_W,  32'h0C, 32'h0, SPLIT ? 32'h3344BABE : 32'hCAFEBABE, 0, 0, 1);
    add(0, F3_W,  32'h10, 32'h0, SPLIT ? 32'h80001122 : 32'h800000FF, 0, 0, 1);
    add(0, F3_W,  32'h0E, 32'h0, SPLIT ? 32'h11223344 : 32'h0, !SPLIT, 0, SPLIT ? 2 : 1);
    add(0, F3_H,  32'h11, 32'h0, SPLIT ? 32'h00000011 : 32'h0, !SPLIT, 0, 1);
    add(1, F3_W,  32'h3C, 32'hA1B2C3D4, 32'h0, 0, 0, 1);
    add(1, F3_W,  32'h00, 32'h5566778F, 32'h0, 0, 0, 1);
    add(0, F3_HU, 32'h3F, 32'h0, SPLIT ? 32'h00008FA1 : 32'h0, !SPLIT, 0, SPLIT ? 2 : 1);
    add(0, F3_H,  32'h3F, 32'h0, SPLIT ? 32'hFFFF8FA1 : 32'h0, !SPLIT, 0, SPLIT ? 2 : 1);
    add(0, F3_W,  32'h3D, 32'h0, SPLIT ? 32'h8FA1B2C3 : 32'h0, !SPLIT, 0, SPLIT ? 2 : 1);
    add(0, F3_W,  32'h40, 32'h0, 32'h5566778F, 0, 0, 1);
    add(0, F3_BU, 32'hFFFFFF3D, 32'h0, 32'h000000C3, 0, 0, 1);
    add(1, F3_W,  32'h2C, 32'h0, 32'h0, 0, 0, 1);
    add(1, F3_W,  32'h30, 32'h0, 32'h0, 0, 0, 1);

    foreach (vecs[i]) do_req(vecs[i]);
    repeat (3) @(negedge clk);

    // store crossing 0x2C/0x30, reset asserted while the second half is pending
    req_valid = 1'b1; req_we = 1'b1; funct3 = F3_W; addr = 32'h2E; wdata = 32'hFFEEDDCC;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_state", 64'(dbg_state), 64'(IDLE));
    chk("abort_rsp_valid", 64'(rsp_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_no_pending", 64'(exp_q.size()), 64'(0));
    v.we = 0; v.f3 = F3_W; v.wdata = 32'h0; v.mis = 0; v.ill = 0; v.lat = 1;
    v.addr = 32'h2C; v.rdata = SPLIT ? 32'hDDCC0000 : 32'h0;
    do_req(v);
    v.addr = 32'h30; v.rdata = 32'h0;
    do_req(v);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
